// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and constants for the data memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam int MEM_BYTES_DEF = 64;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's word load/store handshake toward the arbiter
interface dmem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic req, we, ack, err;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_rr_picker.sv
// dmem_rr_picker: combinational 2-way picker, pointer breaks ties
module dmem_rr_picker
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       valid
);
  logic win;
  always_comb begin
    valid = |req;
    win = &req ? ptr : (req[1] ? PORT1 : PORT0);
    gnt = valid ? (win ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port word access sequencer for the data memory; define DMEM_ARB_RR_EN for round-robin arbitration
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state;
  logic ptr, win, valid, sel_we, legal;
  logic [1:0] gnt, ack, err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rdata [2];
  dmem_rr_picker u_pick (.req({p1.req, p0.req}), .ptr(ptr), .gnt(gnt), .valid(valid));
  always_comb begin
    sel_we = gnt[0] ? p0.we : p1.we;
    sel_addr = gnt[0] ? p0.addr : p1.addr;
    sel_wdata = gnt[0] ? p0.wdata : p1.wdata;
    legal = ((sel_addr[1:0] & ALIGN_MASK) == 2'b00) && (sel_addr <= ADDR_W'(MEM_BYTES - 4));
  end
`ifdef DMEM_ARB_RR_EN
  // error grants move the pointer too, so a port spamming bad addresses cannot starve the other
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= PORT0;
    else if (state == IDLE && valid) ptr <= ~gnt[1];
`else
  assign ptr = PORT0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      win <= PORT0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ack <= '0;
      err <= '0;
      rdata[0] <= '0;
      rdata[1] <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: if (valid) begin
          win <= gnt[1];
          mem_addr <= sel_addr;
          mem_wdata <= sel_wdata;
          mem_read <= legal & ~sel_we;
          mem_write <= legal & sel_we;
          ack <= legal ? 2'b00 : gnt;
          err <= legal ? 2'b00 : gnt;
          state <= legal ? ACCESS : DONE;
        end
        ACCESS: begin
          mem_read <= 1'b0;
          mem_write <= 1'b0;
          if (mem_read) rdata[win] <= mem_rdata;
          ack[win] <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  assign p0.ack = ack[0];
  assign p1.ack = ack[1];
  assign p0.err = err[0];
  assign p1.err = err[1];
  assign p0.rdata = rdata[0];
  assign p1.rdata = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table, random and corner-sequence checks of dmem_arbiter against a big-endian memory model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [7:0] mem [64];
  logic [7:0] gold [64];
  logic [31:0] rd_model [2];
  int vectors = 0;
  int miscompares = 0;
  bit prev_stb = 1'b0;
  typedef struct {int port; bit we; logic [31:0] addr; logic [31:0] wdata; bit err; logic [31:0] rdata;} vec_t;
  vec_t tbl [12];
`ifdef DMEM_ARB_RR_EN
  int exp_order [4] = '{0, 1, 0, 1};
`else
  int exp_order [4] = '{0, 0, 1, 1};
`endif

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1 ();

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .p0(p0), .p1(p1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  function automatic logic [31:0] gword(input int a);
    return {gold[a], gold[a+1], gold[a+2], gold[a+3]};
  endfunction

  function automatic logic ack_of(input int p);
    return p == 1 ? p1.ack : p0.ack;
  endfunction

  function automatic logic err_of(input int p);
    return p == 1 ? p1.err : p0.err;
  endfunction

  function automatic logic [31:0] rd_of(input int p);
    return p == 1 ? p1.rdata : p0.rdata;
  endfunction

  task automatic drive(input int p, input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 1) begin
      p1.req = req; p1.we = we; p1.addr = addr; p1.wdata = wdata;
    end else begin
      p0.req = req; p0.we = we; p0.addr = addr; p0.wdata = wdata;
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_mem_read"}, mem_read, 0);
    chk({nm, "_mem_write"}, mem_write, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
    chk({nm, "_acks"}, {p1.ack, p0.ack, p1.err, p0.err}, 0);
    chk({nm, "_p0_rdata"}, p0.rdata, 0);
    chk({nm, "_p1_rdata"}, p1.rdata, 0);
  endtask

  // one single-port transaction; called only when the arbiter is idle
  task automatic txn(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit exp_err, input logic [31:0] exp_rd);
    int n = 0;
    bit got = 1'b0;
    int q = 1 - p;
    drive(p, 1, we, addr, wdata);
    while (!got && n < 8) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        chk("strobe_rd", mem_read, !exp_err && !we);
        chk("strobe_wr", mem_write, !exp_err && we);
        if (!exp_err) chk("mem_addr", mem_addr, addr);
        if (!exp_err && we) chk("mem_wdata", mem_wdata, wdata);
      end
      chk("other_ack", {ack_of(q), err_of(q)}, 0);
      chk("other_rdata", rd_of(q), rd_model[q]);
      got = ack_of(p);
    end
    drive(p, 0, 0, 0, 0);
    chk("ack_seen", got, 1);
    chk("ack_latency", n, exp_err ? 1 : 2);
    chk("err", err_of(p), exp_err);
    chk("rdata", rd_of(p), exp_rd);
    rd_model[p] = exp_rd;
    if (!exp_err && we) {gold[addr], gold[addr+1], gold[addr+2], gold[addr+3]} = wdata;
    @(posedge clk); #1;
    chk("ack_pulse", {ack_of(p), err_of(p)}, 0);
    chk("strobe_idle", {mem_read, mem_write}, 0);
  endtask

  // negedge-clocked big-endian memory plus strobe-spacing monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && (mem_read || mem_write)) begin
      chk("strobe_gap", prev_stb, 0);
      chk("strobe_excl", mem_read & mem_write, 0);
    end
    if (mem_write) {mem[mem_addr[5:0]], mem[mem_addr[5:0]+6'd1], mem[mem_addr[5:0]+6'd2], mem[mem_addr[5:0]+6'd3]} = mem_wdata;
    if (mem_read) mem_rdata = mword(int'(mem_addr[5:0]));
    prev_stb = rst_n & (mem_read | mem_write);
  end

  initial begin
    int k;
    int rem [2];
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'h00;
      gold[i] = 8'h00;
    end
    rd_model[0] = '0;
    rd_model[1] = '0;
    tbl[0]  = '{0, 1'b1, 32'd8,          32'hDEADBEEF, 1'b0, 32'h00000000};
    tbl[1]  = '{0, 1'b0, 32'd8,          32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1, 1'b0, 32'd6,          32'h0,        1'b1, 32'h00000000};
    tbl[3]  = '{0, 1'b1, 32'd60,         32'h12345678, 1'b0, 32'hDEADBEEF};
    tbl[4]  = '{0, 1'b0, 32'd60,         32'h0,        1'b0, 32'h12345678};
    tbl[5]  = '{0, 1'b0, 32'd64,         32'h0,        1'b1, 32'h12345678};
    tbl[6]  = '{1, 1'b1, 32'd4,          32'hCAFEF00D, 1'b0, 32'h00000000};
    tbl[7]  = '{1, 1'b0, 32'd4,          32'h0,        1'b0, 32'hCAFEF00D};
    tbl[8]  = '{1, 1'b0, 32'd6,          32'h0,        1'b1, 32'hCAFEF00D};
    tbl[9]  = '{0, 1'b1, 32'd2,          32'h55555555, 1'b1, 32'h12345678};
    tbl[10] = '{1, 1'b0, 32'hFFFFFFFC,   32'h0,        1'b1, 32'hCAFEF00D};
    tbl[11] = '{1, 1'b0, 32'd8,          32'h0,        1'b0, 32'hDEADBEEF};
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check_zero("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("after_reset");

    for (int i = 0; i < 12; i++)
      txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].rdata);
    chk("mem_word_8", mword(8), 32'hDEADBEEF);
    chk("mem_word_60", mword(60), 32'h12345678);

    for (int i = 0; i < 40; i++) begin
      int p = int'($urandom_range(0, 1));
      bit we = 1'($urandom_range(0, 1));
      int kind = int'($urandom_range(0, 3));
      logic [31:0] a = kind < 2 ? 32'($urandom_range(0, 15) * 4)
                     : kind == 2 ? 32'($urandom_range(0, 14) * 4 + $urandom_range(1, 3))
                     : 32'(64 + $urandom_range(0, 15) * 4);
      logic [31:0] wd = $urandom;
      bit bad = (a % 4 != 0) || (a > 60);
      txn(p, we, a, wd, bad, (!bad && !we) ? gword(int'(a)) : rd_model[p]);
    end
    for (int a = 0; a < 64; a += 4) chk("mem_vs_model", mword(a), gword(a));

    drive(0, 1, 1, 32'd4, 32'h11111111);
    @(posedge clk); #1;
    chk("rst_access_wr", mem_write, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_strobe_drop", {mem_read, mem_write}, 0);
    drive(0, 0, 0, 0, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_no_ack", {p0.ack, p1.ack}, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("rst_release");
    chk("rst_word_4", mword(4), gword(4));
    rd_model[0] = '0;
    rd_model[1] = '0;

    rem[0] = 2;
    rem[1] = 2;
    k = 0;
    drive(0, 1, 0, 32'd8, 0);
    drive(1, 1, 0, 32'd4, 0);
    for (int c = 0; c < 30 && (rem[0] > 0 || rem[1] > 0); c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++)
        if (ack_of(p)) begin
          chk("tie_order", p, k < 4 ? exp_order[k] : 9);
          chk("tie_rdata", rd_of(p), gword(p == 1 ? 4 : 8));
          k++;
          rem[p]--;
          if (rem[p] == 0) drive(p, 0, 0, 0, 0);
        end
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 chk("tie_ack_count", k, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
